// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, SCLK idle level and the Option<byte> bundle.
package spi_pkg;

  localparam int BITS_PER_FRAME = 8;
  localparam int SYNC_STAGES    = 2;

  localparam int unsigned DEFAULT_IDLE_TIMEOUT = 2048;

  // SCLK rests high between frames; spi_tx drives the same level when idle.
  localparam logic SCLK_IDLE = 1'b1;

  localparam logic TAG_SOME = 1'b0;
  localparam logic TAG_NONE = 1'b1;

  typedef logic [BITS_PER_FRAME-1:0] byte_t;

  typedef struct packed {
    logic  tag;
    byte_t data;
  } opt_byte_t;

  localparam opt_byte_t OPT_NONE = '{tag: TAG_NONE, data: '0};

  typedef struct packed {
    opt_byte_t received;
    logic      busy;
    logic      frame_error;
  } rx_out_t;

  function automatic opt_byte_t some(input byte_t d);
    return '{tag: TAG_SOME, data: d};
  endfunction

endpackage

// File: rtl/spi_rx_edge_sync.sv
// Two-flop synchronisers for SCLK/MOSI plus the SCLK falling-edge detector.
module spi_rx_edge_sync
  import spi_pkg::*;
(
  input  logic _i_clk,
  input  logic _i_rst,
  input  logic sclk,
  input  logic mosi,
  output logic mosi_sync,
  output logic sclk_fall
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   sclk_prev;
  logic                   armed;
  logic [SETTLE_W-1:0]    settle_cnt;

  // Edges are only honoured once a genuine high SCLK has passed through the
  // synchroniser, so a pin held low across reset release cannot fake a fall.
  always_ff @(posedge _i_clk) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
    if (_i_rst) begin
      sclk_ff    <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_ff    <= '0;
      sclk_prev  <= SCLK_IDLE;
      armed      <= 1'b0;
      settle_cnt <= '0;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_ff[SYNC_STAGES-1];
      if (settle_cnt != SETTLE_DONE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else if (sclk_ff[SYNC_STAGES-1]) begin
        armed <= 1'b1;
      end
    end
  end

  assign mosi_sync = mosi_ff[SYNC_STAGES-1];
  assign sclk_fall = armed & sclk_prev & ~sclk_ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI receiver (SCLK idle high, sample on fall, LSB first); emits one-cycle Some(byte).
// Optional mid-frame idle timeout enabled by defining SPI_RX_FRAME_TIMEOUT_EN.
module spi_rx
  import spi_pkg::*;
`ifdef SPI_RX_FRAME_TIMEOUT_EN
#(
  parameter int unsigned IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
)
`endif
(
  input  logic        _i_clk,
  input  logic        _i_rst,
  input  logic        _i_sclk,
  input  logic        _i_mosi,
  output logic [10:0] __output
);

  localparam int IDX_W = $clog2(BITS_PER_FRAME);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(BITS_PER_FRAME - 1);

  logic mosi_sync;
  logic sclk_fall;
  logic timeout;

  logic [IDX_W-1:0] bit_idx, bit_idx_next;
  byte_t            shift_q, shift_next;
  opt_byte_t        received_q, received_next;
  logic             busy_q;
  logic             frame_error_q, frame_error_next;
  rx_out_t          out_bundle;

  spi_rx_edge_sync u_edge_sync (
    ._i_clk    (_i_clk),
    ._i_rst    (_i_rst),
    .sclk      (_i_sclk),
    .mosi      (_i_mosi),
    .mosi_sync (mosi_sync),
    .sclk_fall (sclk_fall)
  );

`ifdef SPI_RX_FRAME_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // A coincident falling edge takes priority over the timeout in the next-state logic.
  assign timeout = (bit_idx != '0) && (idle_cnt == 16'(IDLE_TIMEOUT - 1));

  always_ff @(posedge _i_clk) begin
    if (_i_rst || sclk_fall || bit_idx == '0 || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    bit_idx_next     = bit_idx;
    shift_next       = shift_q;
    received_next    = OPT_NONE;
    frame_error_next = 1'b0;
    if (sclk_fall) begin
      shift_next[bit_idx] = mosi_sync;
      if (bit_idx == LAST_BIT) begin
        received_next = some(shift_next);
        bit_idx_next  = '0;
      end else begin
        bit_idx_next = bit_idx + 1'b1;
      end
    end else if (timeout) begin
      bit_idx_next     = '0;
      shift_next       = '0;
      frame_error_next = 1'b1;
    end
  end

  // busy tracks the post-edge index so it drops on the same cycle the Some appears.
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      bit_idx       <= '0;
      shift_q       <= '0;
      received_q    <= OPT_NONE;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      bit_idx       <= bit_idx_next;
      shift_q       <= shift_next;
      received_q    <= received_next;
      busy_q        <= (bit_idx_next != '0);
      frame_error_q <= frame_error_next;
    end
  end

  assign out_bundle = '{received: received_q, busy: busy_q, frame_error: frame_error_q};
  assign __output   = out_bundle;

endmodule

// File: doc/spi_rx.md
# spi_rx

SPI receive-side block (mode matching `spi_tx`: SCLK idles high, data launched while SCLK high, sampled on SCLK falling edge, LSB first, 8-bit frames, no chip-select). Synchronises the incoming SCLK/MOSI pins into the local clock domain, detects SCLK falling edges, and deserialises them into bytes. Each completed byte is presented as a one-cycle `Some(byte)` on the output bundle. It sits at the pin boundary as the counterpart of `spi_tx` and serves as its loopback checker in system benches.

## Interface
- `IDLE_TIMEOUT`, 2048: cycles without a falling SCLK edge, mid-frame, before the partial frame is discarded. Active only with the macro. Range 16..65535.
- `_i_clk` in 1: system clock.
- `_i_rst` in 1: synchronous, active-high reset.
- `_i_sclk` in 1: SPI clock pin, asynchronous to `_i_clk`, idles high.
- `_i_mosi` in 1: SPI data pin, asynchronous.
- `__output` out 11: `{received[8:0], busy, frame_error}`.
  - `received` is `Option<uint<8>>`: bit 8 is the tag (0 = Some, 1 = None). Bits 7:0 hold the data and are 0 when None.

## Operation
- Both `_i_sclk` and `_i_mosi` pass through 2-flop synchronisers.
- A falling edge is detected when the previous synchronised SCLK is 1 and the current synchronised SCLK is 0.
- State: `bit_idx` (0..7, 3 bits) and an 8-bit shift register.
- On each falling edge:
  - `shift[bit_idx] <= mosi_sync`.
  - If `bit_idx == 7`: `received <= Some({mosi_sync, shift[6:0]})` for exactly one cycle, then `bit_idx <= 0`.
  - Otherwise `bit_idx <= bit_idx + 1`.
- `busy = (bit_idx != 0)`, registered.
- `received` returns to None the cycle after a Some. A Some is never held for two cycles.
- Rising SCLK edges are ignored.
- Back-to-back frames need no gap: the first falling edge after a completed byte begins a new frame.
- Reset, including mid-frame:
  - Synchroniser SCLK flops go to 1, MOSI flops to 0.
  - `bit_idx` = 0, shift register = 0.
  - `received` = None (`9'b1_0000_0000`), `busy` = 0, `frame_error` = 0.
  - Any partial frame is discarded.
  - A pin SCLK low during reset release does not produce a spurious edge.

## Timing
- Pin falling edge sampled at cycle n:
  - Sync stage 1 at n+1, stage 2 at n+2.
  - Edge detect and shift at n+3.
  - `received`/`busy` update visible from n+3.
- Edge-to-output latency is 3 cycles, fixed.
- MOSI must be stable for at least 3 `_i_clk` cycles around the SCLK falling edge. Each SCLK phase must be at least 3 cycles long; shorter pulses may be missed.
- `spi_tx` at 500 cycles per half-bit: Some appears 3 cycles after the 8th falling edge, i.e. about 7503 cycles after the first MOSI launch.

## Configuration
- `SPI_RX_FRAME_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every falling edge or whenever `bit_idx == 0`, and otherwise increments.
  - On reaching `IDLE_TIMEOUT`: `bit_idx <= 0`, the partial byte is dropped, and `frame_error` pulses for 1 cycle. No Some is emitted.
  - If a falling edge coincides with the timeout cycle, the edge wins: it is sampled and the counter clears.
- Undefined: no counter, and `frame_error` is tied to 0. A partial frame persists indefinitely until reset or its remaining edges arrive.

## Structure
- Shared package `spi_pkg`:
  - Option tag constants.
  - `BITS_PER_FRAME = 8`, `SYNC_STAGES = 2`.
  - Default `IDLE_TIMEOUT`.
  - SCLK idle level constant, also to be used by `spi_tx`.
- One sub-module, `spi_rx_edge_sync`:
  - Contains both synchronisers and the falling-edge detector.
  - Outputs: `mosi_sync`, `sclk_fall`.
  - Takes `_i_clk`/`_i_rst`.

## Test plan
- Reset held 4 cycles with SCLK=1 → `__output = 11'b1_0000_0000_0_0` throughout and for 100 cycles after release.
- Loopback from `spi_tx` sending Some(0xB2) → exactly one cycle of `received = 9'b0_1011_0010`. `busy` is 1 from 3 cycles after the first falling edge until the Some cycle, and 0 on the Some cycle.
- Directly driven frames 0x00, 0xFF, 0xA5 back-to-back, 10 cycles per half-bit, no gap → three single-cycle Somes with those values, each 3 cycles after every 8th falling edge.
- `_i_rst` asserted after 4 bits of 0xFF, then a full 0x3C frame → only Some(0x3C) is seen; no byte mixes 0xF and 0x3C bits.
- With `SPI_RX_FRAME_TIMEOUT_EN` and `IDLE_TIMEOUT=64`: 3 bits, then SCLK held high for 200 cycles → `frame_error` pulses once, `busy` returns to 0, and a following 0x81 frame yields Some(0x81).
- 1-cycle SCLK low glitch → no `bit_idx` advance, or exactly one advance; never two. The bench checks `busy` and the next byte's alignment accordingly.
